// File: rtl/dmem_responder.sv
//==============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the core's load/store port. Adds a
//               programmable number of wait states (reported on stall), pulses
//               valid when an access commits and err when one is rejected.
//               Optional access counters are enabled by the macro
//               DMEM_ACCESS_CNT_EN (adds ld_cnt / st_cnt outputs).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              valid,
    output logic              err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       ld_cnt,
    output logic [15:0]       st_cnt
`endif
);

    // Storage index width; addresses at or above DEPTH never reach the array.
    localparam int         c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit         c_ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] c_WAIT_LOAD = c_ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;

    // Copy of the request taken when entering WAIT; the live inputs are
    // ignored until the access commits.
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_req;
    logic                w_both;
    logic                w_latch;
    logic                w_stall;
    logic                w_illegal;
    logic                w_commit;
    logic                w_commit_wr;
    logic [ADDR_W-1:0]   w_commit_addr;
    logic [DATA_W-1:0]   w_commit_data;
    logic                w_in_range;
    logic                w_commit_ok;
    logic                w_commit_oor;
    logic [c_IDX_W-1:0]  w_idx;

    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    assign w_req  = wr ^ rd;
    assign w_both = wr & rd;

    // Next-state, wait counter and commit selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_latch       = 1'b0;
        w_stall       = 1'b0;
        w_illegal     = 1'b0;
        w_commit      = 1'b0;
        w_commit_wr   = r_op_wr;
        w_commit_addr = r_addr;
        w_commit_data = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_both) begin
                    w_illegal = 1'b1;
                end else if (w_req) begin
                    if (c_ZERO_WAIT) begin
                        w_commit      = 1'b1;
                        w_commit_wr   = wr;
                        w_commit_addr = addr;
                        w_commit_data = wr_data;
                    end else begin
                        w_latch     = 1'b1;
                        w_stall     = 1'b1;
                        w_cnt_nxt   = c_WAIT_LOAD;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Range check happens at commit, so out-of-range accesses still wait.
    assign w_in_range   = (32'(w_commit_addr) < 32'(DEPTH));
    assign w_commit_ok  = w_commit & w_in_range;
    assign w_commit_oor = w_commit & ~w_in_range;
    assign w_idx        = w_commit_addr[c_IDX_W-1:0];

    // Stall is forced low while reset is held.
    assign stall = w_stall & reset;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the request when it is accepted into WAIT.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_op_wr <= wr;
            r_addr  <= addr;
            r_wdata <= wr_data;
        end
    end

    // Word storage; contents survive reset but no store commits during it.
    always_ff @(posedge clk) begin
        if (reset && w_commit_ok && w_commit_wr) begin
            r_mem[w_idx] <= w_commit_data;
        end
    end

    // Load data register and the valid / err completion pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= w_commit_ok;
            err   <= w_commit_oor | w_illegal;
            if (w_commit_ok && !w_commit_wr) begin
                rd_data <= r_mem[w_idx];
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    // Saturating counters of committed in-range loads and stores.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_cnt <= 16'd0;
            st_cnt <= 16'd0;
        end else if (w_commit_ok) begin
            if (w_commit_wr) begin
                if (st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
            end else begin
                if (ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//==============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Instance A runs with
//               zero wait states, instance B with three wait states and a
//               256-word depth. Optional counters checked under
//               DMEM_ACCESS_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_responder;

    typedef struct {
        logic        is_err;
        logic [31:0] rd;
    } exp_t;

    logic        tb_clk = 1'b0;
    logic        reset;

    logic        a_wr, a_rd, a_stall, a_valid, a_err;
    logic [8:0]  a_addr;
    logic [31:0] a_wr_data, a_rd_data;
    logic        b_wr, b_rd, b_stall, b_valid, b_err;
    logic [8:0]  b_addr;
    logic [31:0] b_wr_data, b_rd_data;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] a_ld_cnt, a_st_cnt, b_ld_cnt, b_st_cnt;
`endif

    int          errors = 0;
    int          checks = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] a_model_mem [logic [8:0]];
    logic [31:0] b_model_mem [logic [8:0]];
    logic [31:0] a_model_rd;
    logic [31:0] b_model_rd;

    always #5 tb_clk = ~tb_clk;

    dmem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(0)) u_dut_a (
        .clk     (tb_clk),
        .reset   (reset),
        .wr      (a_wr),
        .rd      (a_rd),
        .addr    (a_addr),
        .wr_data (a_wr_data),
        .rd_data (a_rd_data),
        .stall   (a_stall),
        .valid   (a_valid),
        .err     (a_err)
`ifdef DMEM_ACCESS_CNT_EN
        ,
        .ld_cnt  (a_ld_cnt),
        .st_cnt  (a_st_cnt)
`endif
    );

    dmem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut_b (
        .clk     (tb_clk),
        .reset   (reset),
        .wr      (b_wr),
        .rd      (b_rd),
        .addr    (b_addr),
        .wr_data (b_wr_data),
        .rd_data (b_rd_data),
        .stall   (b_stall),
        .valid   (b_valid),
        .err     (b_err)
`ifdef DMEM_ACCESS_CNT_EN
        ,
        .ld_cnt  (b_ld_cnt),
        .st_cnt  (b_st_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard for instance A: every completion pulse pops one expectation.
    always @(negedge tb_clk) begin
        if (a_valid === 1'b1 || a_err === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_spurious", 32'({a_valid, a_err}), 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_err", 32'(a_err), 32'(e.is_err));
                chk("a_valid", 32'(a_valid), 32'(!e.is_err));
                chk("a_rd_data", a_rd_data, e.rd);
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge tb_clk) begin
        if (b_valid === 1'b1 || b_err === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_spurious", 32'({b_valid, b_err}), 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_err", 32'(b_err), 32'(e.is_err));
                chk("b_valid", 32'(b_valid), 32'(!e.is_err));
                chk("b_rd_data", b_rd_data, e.rd);
            end
        end
    end

    // Zero-wait access: one request per cycle, result one cycle later.
    task automatic a_step(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d);
        exp_t e;
        if (w && r) begin
            e.is_err = 1'b1;
        end else begin
            e.is_err = 1'b0;
            if (w) a_model_mem[a] = d;
            else   a_model_rd = a_model_mem[a];
        end
        e.rd = a_model_rd;
        qa.push_back(e);
        a_wr = w; a_rd = r; a_addr = a; a_wr_data = d;
        @(negedge tb_clk);
        chk("a_stall", 32'(a_stall), 32'd0);
        @(posedge tb_clk); #1;
        chk("a_pending", 32'(qa.size()), 32'd1);
    endtask

    // Three-wait access on B: hold while stalled, then expect completion.
    task automatic b_op(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        logic st;
        if (w && r) begin
            e.is_err = 1'b1; n = 1; st = 1'b0;
        end else begin
            n = 4; st = 1'b1;
            if (a >= 9'd256) begin
                e.is_err = 1'b1;
            end else begin
                e.is_err = 1'b0;
                if (w) b_model_mem[a] = d;
                else   b_model_rd = b_model_mem[a];
            end
        end
        e.rd = b_model_rd;
        qb.push_back(e);
        b_wr = w; b_rd = r; b_addr = a; b_wr_data = d;
        for (int i = 0; i < n; i++) begin
            @(negedge tb_clk);
            chk("b_stall", 32'(b_stall), 32'(st));
            @(posedge tb_clk); #1;
        end
        b_wr = 1'b0; b_rd = 1'b0;
        @(posedge tb_clk); #1;
        chk("b_latency", 32'(qb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        a_wr = 1'b0; a_rd = 1'b1; a_addr = 9'd5; a_wr_data = 32'd0;
        b_wr = 1'b0; b_rd = 1'b1; b_addr = 9'd5; b_wr_data = 32'd0;
        a_model_rd = 32'd0;
        b_model_rd = 32'd0;

        // Reset with requests present: outputs and stall stay low.
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        chk("rst_a_stall", 32'(a_stall), 32'd0);
        chk("rst_b_stall", 32'(b_stall), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_err", 32'(b_err), 32'd0);
        chk("rst_a_rd_data", a_rd_data, 32'd0);
        chk("rst_b_rd_data", b_rd_data, 32'd0);
        @(posedge tb_clk); #1;
        reset = 1'b1;
        a_rd = 1'b0; b_rd = 1'b0;
        @(posedge tb_clk); #1;

        // Zero-wait instance: back-to-back traffic.
        a_step(1'b1, 1'b0, 9'd5, 32'hDEADBEEF);
        a_step(1'b0, 1'b1, 9'd5, 32'd0);
        a_step(1'b1, 1'b1, 9'd7, 32'h0BAD0BAD);
        a_step(1'b1, 1'b0, 9'd6, 32'h12345678);
        a_step(1'b0, 1'b1, 9'd6, 32'd0);
        a_step(1'b0, 1'b1, 9'd5, 32'd0);
        a_wr = 1'b0; a_rd = 1'b0;
        @(posedge tb_clk); #1;
        chk("a_drain", 32'(qa.size()), 32'd0);
`ifdef DMEM_ACCESS_CNT_EN
        chk("a_st_cnt", 32'(a_st_cnt), 32'd2);
        chk("a_ld_cnt", 32'(a_ld_cnt), 32'd3);
`endif

        // Wait-state instance: normal, illegal and out-of-range accesses.
        b_op(1'b1, 1'b0, 9'd5, 32'hDEADBEEF);
        b_op(1'b0, 1'b1, 9'd5, 32'd0);
        b_op(1'b1, 1'b0, 9'd7, 32'h00000077);
        b_op(1'b1, 1'b1, 9'd7, 32'h0BAD0BAD);
        b_op(1'b0, 1'b1, 9'd7, 32'd0);
        b_op(1'b0, 1'b1, 9'd5, 32'd0);
        b_op(1'b1, 1'b0, 9'd300, 32'h0000AAAA);
        b_op(1'b0, 1'b1, 9'd300, 32'd0);
        b_op(1'b1, 1'b0, 9'd9, 32'h00000000);

        // Reset in the middle of a waited store to word 9.
        b_wr = 1'b1; b_addr = 9'd9; b_wr_data = 32'h00000001;
        @(posedge tb_clk); #1;
        reset = 1'b0;
        @(negedge tb_clk);
        chk("midrst_stall", 32'(b_stall), 32'd0);
        @(posedge tb_clk); #1;
        reset = 1'b1;
        b_wr = 1'b0;
        b_model_rd = 32'd0;
        @(negedge tb_clk);
        chk("midrst_valid", 32'(b_valid), 32'd0);
        chk("midrst_err", 32'(b_err), 32'd0);
        chk("midrst_stall_idle", 32'(b_stall), 32'd0);
        chk("midrst_rd_data", b_rd_data, 32'd0);
        @(posedge tb_clk); #1;
        b_op(1'b0, 1'b1, 9'd9, 32'd0);

        b_op(1'b1, 1'b0, 9'd10, 32'hA5A5A5A5);
        b_op(1'b1, 1'b0, 9'd11, 32'h5A5A5A5A);
        b_op(1'b1, 1'b0, 9'd12, 32'hFFFFFFFF);
        b_op(1'b0, 1'b1, 9'd10, 32'd0);
        b_op(1'b1, 1'b1, 9'd11, 32'd0);
        b_op(1'b1, 1'b0, 9'd400, 32'h12121212);
        b_op(1'b0, 1'b1, 9'd11, 32'd0);
        b_op(1'b0, 1'b1, 9'd12, 32'd0);
`ifdef DMEM_ACCESS_CNT_EN
        chk("b_st_cnt", 32'(b_st_cnt), 32'd3);
        chk("b_ld_cnt", 32'(b_ld_cnt), 32'd4);
`endif

        repeat (3) @(posedge tb_clk);
        #1;
        chk("final_qa", 32'(qa.size()), 32'd0);
        chk("final_qb", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
